// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with STAGES slices, per-slot valid, stall/flush control.
// Optional saturating retired/bubble counters when MEM_WB_PERF_COUNTERS_EN is defined.
module mem_wb_pipe_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STAGES         = 1,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      valid_memory,
  input  logic                      register_write_memory,
  input  logic                      memory_to_register_memory,
  input  logic [DATA_WIDTH-1:0]     ALU_out_memory,
  input  logic [DATA_WIDTH-1:0]     read_data_memory,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_memory,
  output logic                      valid_writeback,
  output logic                      register_write_writeback,
  output logic                      memory_to_register_writeback,
  output logic [DATA_WIDTH-1:0]     ALU_out_writeback,
  output logic [DATA_WIDTH-1:0]     read_data_writeback,
  output logic [REG_ADDR_WIDTH-1:0] write_register_writeback,
  output logic [DATA_WIDTH-1:0]     result_writeback,
  output logic                      register_file_write_enable
`ifdef MEM_WB_PERF_COUNTERS_EN
  ,
  output logic [COUNT_WIDTH-1:0]    retired_count,
  output logic [COUNT_WIDTH-1:0]    bubble_count
`endif
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mem_wb_pipe_reg: STAGES must be in 1..4");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count_width
      $error("mem_wb_pipe_reg: COUNT_WIDTH must be at least 1");
    end
  endgenerate

  logic [STAGES-1:0]                     valid_q, valid_d;
  logic [STAGES-1:0]                     rw_q, rw_d;
  logic [STAGES-1:0]                     m2r_q, m2r_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0]     alu_q, alu_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [STAGES-1:0][REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;

  // Flush clears only the control bits; datapath fields are left alone to avoid toggling.
  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    wreg_d  = wreg_q;
    if (flush) begin
      valid_d = '0;
      rw_d    = '0;
      m2r_d   = '0;
    end else if (!stall) begin
      valid_d[0] = valid_memory;
      rw_d[0]    = register_write_memory & valid_memory;
      m2r_d[0]   = memory_to_register_memory & valid_memory;
      alu_d[0]   = ALU_out_memory;
      rdata_d[0] = read_data_memory;
      wreg_d[0]  = write_register_memory;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        rw_d[k]    = rw_q[k-1];
        m2r_d[k]   = m2r_q[k-1];
        alu_d[k]   = alu_q[k-1];
        rdata_d[k] = rdata_q[k-1];
        wreg_d[k]  = wreg_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      rw_q    <= '0;
      m2r_q   <= '0;
      alu_q   <= '0;
      rdata_q <= '0;
      wreg_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      wreg_q  <= wreg_d;
    end
  end

  assign valid_writeback              = valid_q[STAGES-1];
  assign register_write_writeback     = rw_q[STAGES-1];
  assign memory_to_register_writeback = m2r_q[STAGES-1];
  assign ALU_out_writeback            = alu_q[STAGES-1];
  assign read_data_writeback          = rdata_q[STAGES-1];
  assign write_register_writeback     = wreg_q[STAGES-1];

  assign result_writeback = memory_to_register_writeback ? read_data_writeback
                                                         : ALU_out_writeback;
  assign register_file_write_enable = valid_writeback & register_write_writeback &
                                      (write_register_writeback != '0);

`ifdef MEM_WB_PERF_COUNTERS_EN
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic [COUNT_WIDTH-1:0] bubble_q, bubble_d;

  // Counts what the WB slot holds on each advancing edge; saturates instead of wrapping.
  always_comb begin
    retired_d = retired_q;
    bubble_d  = bubble_q;
    if (!stall && !flush) begin
      if (valid_writeback) begin
        if (retired_q != '1) retired_d = retired_q + COUNT_WIDTH'(1);
      end else begin
        if (bubble_q != '1) bubble_d = bubble_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      bubble_q  <= '0;
    end else begin
      retired_q <= retired_d;
      bubble_q  <= bubble_d;
    end
  end

  assign retired_count = retired_q;
  assign bubble_count  = bubble_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: STAGES=1,2,3 instances share one stimulus stream and
// are compared against a per-depth slot model; counters checked when MEM_WB_PERF_COUNTERS_EN is set.
module tb_mem_wb_pipe_reg;
  localparam int ND   = 3;
  localparam int CMAX = 3;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
  } rec_t;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        we;
  } out_t;

  logic clk = 1'b0;
  logic reset_n, stall, flush, valid_m, rw_m, m2r_m;
  logic [31:0] alu_m, rd_m;
  logic [4:0]  wr_m;

  logic        vwb[ND], rwwb[ND], m2rwb[ND], wewb[ND];
  logic [31:0] aluwb[ND], rdwb[ND], reswb[ND];
  logic [4:0]  wrwb[ND];
  out_t        got[ND];
`ifdef MEM_WB_PERF_COUNTERS_EN
  logic [1:0]  retc[ND], bubc[ND];
`endif

  rec_t mdl[ND][4];
  int   m_ret[ND], m_bub[ND];
  int   checks, errors;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_wb_pipe_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STAGES(g + 1), .COUNT_WIDTH(2)) u_dut (
      .clk                          (clk),
      .reset_n                      (reset_n),
      .stall                        (stall),
      .flush                        (flush),
      .valid_memory                 (valid_m),
      .register_write_memory        (rw_m),
      .memory_to_register_memory    (m2r_m),
      .ALU_out_memory               (alu_m),
      .read_data_memory             (rd_m),
      .write_register_memory        (wr_m),
      .valid_writeback              (vwb[g]),
      .register_write_writeback     (rwwb[g]),
      .memory_to_register_writeback (m2rwb[g]),
      .ALU_out_writeback            (aluwb[g]),
      .read_data_writeback          (rdwb[g]),
      .write_register_writeback     (wrwb[g]),
      .result_writeback             (reswb[g]),
      .register_file_write_enable   (wewb[g])
`ifdef MEM_WB_PERF_COUNTERS_EN
      ,
      .retired_count                (retc[g]),
      .bubble_count                 (bubc[g])
`endif
    );
  end

  always_comb begin
    for (int d = 0; d < ND; d++)
      got[d] = {vwb[d], rwwb[d], m2rwb[d], aluwb[d], rdwb[d], wrwb[d], reswb[d], wewb[d]};
  end

  // Expected WB view: the instruction that entered depth edges ago, with the architectural rules applied.
  function automatic out_t model_out(int d);
    rec_t r;
    out_t o;
    r = mdl[d][d];
    o.v   = r.v;
    o.rw  = r.rw;
    o.m2r = r.m2r;
    o.alu = r.alu;
    o.rd  = r.rd;
    o.wr  = r.wr;
    o.res = r.m2r ? r.rd : r.alu;
    o.we  = r.v && r.rw && (r.wr != 5'd0);
    return o;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 4; k++) mdl[d][k] = '0;
      m_ret[d] = 0;
      m_bub[d] = 0;
    end
  endtask

  task automatic model_edge();
    rec_t nr;
    if (!reset_n) begin
      model_reset();
      return;
    end
    nr = '{v: valid_m, rw: rw_m & valid_m, m2r: m2r_m & valid_m, alu: alu_m, rd: rd_m, wr: wr_m};
    for (int d = 0; d < ND; d++) begin
      if (!stall && !flush) begin
        if (mdl[d][d].v) m_ret[d] = (m_ret[d] >= CMAX) ? CMAX : m_ret[d] + 1;
        else             m_bub[d] = (m_bub[d] >= CMAX) ? CMAX : m_bub[d] + 1;
      end
      if (flush) begin
        for (int k = 0; k <= d; k++) begin
          mdl[d][k].v   = 1'b0;
          mdl[d][k].rw  = 1'b0;
          mdl[d][k].m2r = 1'b0;
        end
      end else if (!stall) begin
        for (int k = d; k > 0; k--) mdl[d][k] = mdl[d][k-1];
        mdl[d][0] = nr;
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    valid_m = 1'($urandom_range(0, 3) != 0);
    rw_m    = 1'($urandom_range(0, 1));
    m2r_m   = 1'($urandom_range(0, 1));
    alu_m   = $urandom;
    rd_m    = $urandom;
    wr_m    = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      cycle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL reset stages=%0d got=%h exp=%h", d + 1, got[d], model_out(d));
        end
`ifdef MEM_WB_PERF_COUNTERS_EN
        checks++;
        if (retc[d] !== 2'(m_ret[d]) || bubc[d] !== 2'(m_bub[d])) begin
          errors++;
          $display("FAIL reset_counters stages=%0d got=%0d/%0d exp=%0d/%0d", d + 1, retc[d], bubc[d], m_ret[d], m_bub[d]);
        end
`endif
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_pass_through();
    valid_m = 1'b1; rw_m = 1'b1; m2r_m = 1'b0;
    alu_m = 32'h0000_1234; rd_m = 32'h5555_AAAA; wr_m = 5'd5;
    cycle();
    checks++;
    if (reswb[0] !== 32'h0000_1234 || wewb[0] !== 1'b1) begin
      errors++;
      $display("FAIL pass_through_directed got res=%h we=%b exp res=00001234 we=1", reswb[0], wewb[0]);
    end
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      cycle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL pass_through stages=%0d got=%h exp=%h", d + 1, got[d], model_out(d));
        end
      end
    end
  endtask

  task automatic test_depth_select();
    valid_m = 1'b1; rw_m = 1'b1; m2r_m = 1'b1;
    alu_m = 32'hAAAA_0000; rd_m = 32'hDEAD_BEEF; wr_m = 5'd7;
    cycle();
    valid_m = 1'b0;
    for (int e = 2; e <= 4; e++) begin
      cycle();
      if (e == 3) begin
        checks++;
        if (reswb[2] !== 32'hDEAD_BEEF || wewb[2] !== 1'b1 || wrwb[2] !== 5'd7) begin
          errors++;
          $display("FAIL depth3_latency got res=%h we=%b wr=%0d exp res=deadbeef we=1 wr=7", reswb[2], wewb[2], wrwb[2]);
        end
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL depth_select stages=%0d got=%h exp=%h", d + 1, got[d], model_out(d));
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      valid_m = 1'b1;
      cycle();
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      cycle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL stall_hold stages=%0d got=%h exp=%h", d + 1, got[d], model_out(d));
        end
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      cycle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL stall_resume stages=%0d got=%h exp=%h", d + 1, got[d], model_out(d));
        end
      end
    end
  endtask

  task automatic test_flush_priority();
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      valid_m = 1'b1; rw_m = 1'b1; wr_m = 5'(i + 1);
      cycle();
    end
    stall = 1'b1;
    flush = 1'b1;
    drive_rand();
    cycle();
    stall = 1'b0;
    flush = 1'b0;
    valid_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (vwb[d] !== 1'b0 || wewb[d] !== 1'b0 || got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL flush_priority stages=%0d got=%h exp=%h", d + 1, got[d], model_out(d));
        end
      end
      cycle();
    end
  endtask

  task automatic test_reg0_async_reset();
    valid_m = 1'b1; rw_m = 1'b1; m2r_m = 1'b0;
    alu_m = 32'h1111_2222; rd_m = 32'h3333_4444; wr_m = 5'd0;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (wewb[0] !== 1'b0 || wewb[1] !== 1'b0 || wewb[2] !== 1'b0 || vwb[2] !== 1'b1) begin
      errors++;
      $display("FAIL reg0_guard got we=%b%b%b v3=%b exp we=000 v3=1", wewb[0], wewb[1], wewb[2], vwb[2]);
    end
    wr_m = 5'd9;
    cycle();
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (got[d] !== '0) begin
        errors++;
        $display("FAIL async_reset stages=%0d got=%h exp=0", d + 1, got[d]);
      end
`ifdef MEM_WB_PERF_COUNTERS_EN
      checks++;
      if (retc[d] !== 2'd0 || bubc[d] !== 2'd0) begin
        errors++;
        $display("FAIL async_reset_counters stages=%0d got=%0d/%0d exp=0/0", d + 1, retc[d], bubc[d]);
      end
`endif
    end
    reset_n = 1'b1;
    #1;
    valid_m = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      stall = 1'($urandom_range(0, 3) == 0);
      flush = 1'($urandom_range(0, 9) == 0);
      cycle();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (got[d] !== model_out(d)) begin
          errors++;
          $display("FAIL random stages=%0d cyc=%0d got=%h exp=%h", d + 1, i, got[d], model_out(d));
        end
`ifdef MEM_WB_PERF_COUNTERS_EN
        checks++;
        if (retc[d] !== 2'(m_ret[d]) || bubc[d] !== 2'(m_bub[d])) begin
          errors++;
          $display("FAIL counters stages=%0d cyc=%0d got=%0d/%0d exp=%0d/%0d", d + 1, i, retc[d], bubc[d], m_ret[d], m_bub[d]);
        end
`endif
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    valid_m = 1'b0; rw_m = 1'b0; m2r_m = 1'b0;
    alu_m = '0; rd_m = '0; wr_m = '0;
    model_reset();
    test_reset();
    test_pass_through();
    test_depth_select();
    test_stall();
    test_flush_priority();
    test_reg0_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
